// File: rtl/ram_sp_init.sv
// ram_sp_init: parametrised single-port synchronous SRAM model.
//   - generic width/depth, per-bit write mask (DM=1 keeps the stored bit)
//   - functional bypass (BP), optional second output register (OREG)
//   - read-valid strobe (RVLD), hardware zero-init sequencer (BUSY)
// Optional feature: define RAM_PARITY_EN to store one even-parity bit per
// word and report PERR on memory reads; otherwise PERR is tied to 0.
module ram_sp_init #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 14,
  parameter int WORDS  = 16384,
  parameter int OREG   = 0
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              CE,
  input  logic              WE,
  input  logic              BP,
  input  logic [AWIDTH-1:0] IA,
  input  logic [DWIDTH-1:0] I,
  input  logic [DWIDTH-1:0] DM,
  output logic [DWIDTH-1:0] A,
  output logic              RVLD,
  output logic              BUSY,
  output logic              PERR
);

  // Index width of the storage array; never wider than AWIDTH because
  // WORDS <= 2**AWIDTH.
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [AWIDTH:0] WORDS_EXT = (AWIDTH + 1)'(WORDS);
  localparam logic [IDXW-1:0] CNT_LAST  = IDXW'(WORDS - 1);

  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]        state;
  logic [IDXW-1:0]   cnt;

  logic [DWIDTH-1:0] mem [WORDS];
  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] mem_wd;
  logic [IDXW-1:0]   mem_wa;
  logic              mem_we;

  logic              addr_ok;
  logic [IDXW-1:0]   ia_idx;
  logic              acc_en;
  logic              acc_rd;

  logic [DWIDTH-1:0] stage1;
  logic              s1_vld;

`ifdef RAM_PARITY_EN
  logic              mem_par [WORDS];
  logic              rd_par;
  logic              s1_perr;
`endif

  // Address decode: the upper IA bits only matter for the range check.
  assign addr_ok = ({1'b0, IA} < WORDS_EXT);
  assign ia_idx  = IA[IDXW-1:0];

  // Accesses are honoured only once the init sequencer has finished.
  assign acc_en = (state == S_READY) && !CE;
  assign acc_rd = acc_en && (BP || WE);
  assign BUSY   = (state == S_INIT);

  // Init sequencer: walk every word once, then stay READY until reset.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= S_INIT;
      cnt   <= '0;
    end else if (state == S_INIT) begin
      if (cnt == CNT_LAST) begin
        state <= S_READY;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Array read port; out-of-range addresses read as zero.
  always_comb begin
    rd_word = '0;
    if (addr_ok) rd_word = mem[ia_idx];
  end

  // Single write port shared by the init sequencer and masked user writes.
  // The write is gated by RST so contents stay untouched while reset is held.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = ia_idx;
    mem_wd = (rd_word & DM) | (I & ~DM);
    if (!RST) begin
      if (state == S_INIT) begin
        mem_we = 1'b1;
        mem_wa = cnt;
        mem_wd = '0;
      end else if (acc_en && !BP && !WE && addr_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array write.
  // NOTE: the array has no reset; clearing it is the init sequencer's job,
  // which keeps it mappable onto real RAM.
  always_ff @(posedge CK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

`ifdef RAM_PARITY_EN
  // Parity array write; the merged init word is zero, so init stores parity 0.
  always_ff @(posedge CK) begin
    if (mem_we) mem_par[mem_wa] <= ^mem_wd;
  end

  // Stored parity read; out of range reads as zero like the data.
  always_comb begin
    rd_par = 1'b0;
    if (addr_ok) rd_par = mem_par[ia_idx];
  end
`endif

  // Stage-1 read register: bypass data or old memory contents; holds otherwise.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      stage1 <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= acc_rd;
      if (acc_rd) stage1 <= BP ? I : rd_word;
    end
  end

`ifdef RAM_PARITY_EN
  // Stage-1 parity flag: only in-range memory reads can flag an error.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      s1_perr <= 1'b0;
    end else if (acc_rd) begin
      s1_perr <= BP ? 1'b0 : ((^rd_word) ^ rd_par);
    end
  end
`endif

  generate
    if (OREG != 0) begin : g_oreg
      // Second output register: A, RVLD and PERR follow stage 1 one edge later.
      always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
          A    <= '0;
          RVLD <= 1'b0;
        end else begin
          RVLD <= s1_vld;
          if (s1_vld) A <= stage1;
        end
      end
`ifdef RAM_PARITY_EN
      // Delayed parity flag, held between reads like A.
      always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
          PERR <= 1'b0;
        end else if (s1_vld) begin
          PERR <= s1_perr;
        end
      end
`else
      assign PERR = 1'b0;
`endif
    end else begin : g_direct
      assign A    = stage1;
      assign RVLD = s1_vld;
`ifdef RAM_PARITY_EN
      assign PERR = s1_perr;
`else
      assign PERR = 1'b0;
`endif
    end
  endgenerate

endmodule
